// File: rtl/decode_fwd_stage_pkg.sv
// Y86-64 shared definitions: instruction codes, default register indices, E-register control bubble.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] RNONE_DEF   = 4'hF;
  localparam int         RSP_IDX_DEF = 4;

  // Control half of the E register; the datapath half is width-parameterised in the stage.
  typedef struct packed {
    logic [3:0] icode;
    logic [3:0] ifun;
  } e_ctl_t;

  localparam e_ctl_t E_CTL_BUBBLE = '{icode: I_NOP, ifun: 4'h0};

  function automatic logic is_ret(input logic [3:0] icode);
    return icode == I_RET;
  endfunction

endpackage

// File: rtl/decode_fwd_stage_if.sv
// Decode-stage bundle: D-register fields, bypass buses, writeback, E-register outputs, hazards, stats.
// Latency: none (wiring only).
// Backpressure: E_stall holds the E register; load_use_stall asks upstream to hold F/D.
interface decode_fwd_stage_if #(
  parameter int DATA_W = 64,
  parameter int RA_W   = 4
);
  logic [3:0]        D_icode, D_ifun;
  logic [RA_W-1:0]   D_rA, D_rB;
  logic [DATA_W-1:0] D_valC, D_valP;
  logic [RA_W-1:0]   e_dstE;
  logic [DATA_W-1:0] e_valE;
  logic              e_cnd;
  logic [3:0]        M_icode;
  logic [RA_W-1:0]   M_dstE, M_dstM;
  logic [DATA_W-1:0] M_valE, m_valM;
  logic [RA_W-1:0]   W_dstE, W_dstM;
  logic [DATA_W-1:0] W_valE, W_valM;
  logic              E_stall;
  logic [3:0]        E_icode, E_ifun;
  logic [DATA_W-1:0] E_valC, E_valA, E_valB;
  logic [RA_W-1:0]   E_dstE, E_dstM, E_srcA, E_srcB;
  logic [RA_W-1:0]   d_srcA, d_srcB;
  logic              load_use_stall, ret_pending, mispredict;
  logic [RA_W-1:0]   dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [31:0]       fwd_hits, lu_stalls;

  modport master (
    output D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, e_dstE, e_valE, e_cnd,
           M_icode, M_dstE, M_dstM, M_valE, m_valM, W_dstE, W_dstM, W_valE, W_valM,
           E_stall, dbg_addr,
    input  E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB,
           d_srcA, d_srcB, load_use_stall, ret_pending, mispredict, dbg_data,
           fwd_hits, lu_stalls
  );

  modport slave (
    input  D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, e_dstE, e_valE, e_cnd,
           M_icode, M_dstE, M_dstM, M_valE, m_valM, W_dstE, W_dstM, W_valE, W_valM,
           E_stall, dbg_addr,
    output E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB,
           d_srcA, d_srcB, load_use_stall, ret_pending, mispredict, dbg_data,
           fwd_hits, lu_stalls
  );
endinterface

// File: rtl/decode_fwd_stage_regfile.sv
// Architectural register file: two write ports (E, M; M wins on collision), two reads plus debug peek.
// Latency: writes land on the rising edge; reads are combinational.
// Backpressure: none; out-of-range or RNONE indices write nothing and read 0.
module y86_regfile #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int RA_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RA_W-1:0]   wr_e_addr,
  input  logic [DATA_W-1:0] wr_e_data,
  input  logic [RA_W-1:0]   wr_m_addr,
  input  logic [DATA_W-1:0] wr_m_data,
  input  logic [RA_W-1:0]   rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [RA_W-1:0]   rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] regs [NUM_REGS];

  // RNONE is all ones, which is always >= NUM_REGS, so a single range test covers it.
  function automatic logic in_range(input logic [RA_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  function automatic logic [DATA_W-1:0] rd(input logic [RA_W-1:0] a);
    return in_range(a) ? regs[a] : '0;
  endfunction

  // Writeback: the M write is issued last so it overrides E when both target one register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (in_range(wr_e_addr)) regs[wr_e_addr] <= wr_e_data;
      if (in_range(wr_m_addr)) regs[wr_m_addr] <= wr_m_data;
    end
  end

  assign rd_a_data = rd(rd_a_addr);
  assign rd_b_data = rd(rd_b_addr);
  assign dbg_data  = rd(dbg_addr);
endmodule

// File: rtl/decode_fwd_stage.sv
// Y86-64 decode: source/dest select, 5-way operand bypass, hazard detect, D->E register. Stats: DECODE_FWD_STATS_EN.
// Latency: one cycle from D fields to E outputs; hazard flags and d_src are combinational.
// Backpressure: E_stall holds E; load-use or mispredict inserts a bubble, overriding E_stall.
module decode_fwd_stage
  import y86_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15,
  parameter int RA_W     = 4,
  parameter int RSP_IDX  = RSP_IDX_DEF
) (
  input logic               clk,
  input logic               rst_n,
  decode_fwd_stage_if.slave io
);
  localparam logic [RA_W-1:0] RNONE = '1;
  localparam logic [RA_W-1:0] RSP   = RA_W'(RSP_IDX);

  typedef struct packed {
    e_ctl_t            ctl;
    logic [DATA_W-1:0] valC, valA, valB;
    logic [RA_W-1:0]   dstE, dstM, srcA, srcB;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{ctl: E_CTL_BUBBLE, valC: '0, valA: '0, valB: '0,
                                  dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

  logic [RA_W-1:0]   src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;
  logic              use_valp, lu_stall, mispred;
  e_reg_t            e_d, e_q;

  y86_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RA_W(RA_W)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .wr_e_addr(io.W_dstE), .wr_e_data(io.W_valE),
    .wr_m_addr(io.W_dstM), .wr_m_data(io.W_valM),
    .rd_a_addr(src_a), .rd_a_data(rf_a),
    .rd_b_addr(src_b), .rd_b_data(rf_b),
    .dbg_addr(io.dbg_addr), .dbg_data(io.dbg_data)
  );

  // Youngest producer first: execute, then memory load, memory ALU, writeback load, writeback ALU.
  function automatic logic [DATA_W-1:0] fwd_val(input logic [RA_W-1:0] s, input logic [DATA_W-1:0] rf);
    if (s == RNONE)          return '0;
    else if (io.e_dstE == s) return io.e_valE;
    else if (io.M_dstM == s) return io.m_valM;
    else if (io.M_dstE == s) return io.M_valE;
    else if (io.W_dstM == s) return io.W_valM;
    else if (io.W_dstE == s) return io.W_valE;
    else                     return rf;
  endfunction

  // Field selection per instruction class; anything not listed uses no registers.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (io.D_icode)
      I_CMOV:  begin src_a = io.D_rA; dst_e = io.D_rB; end
      I_IRMOV: dst_e = io.D_rB;
      I_RMMOV: begin src_a = io.D_rA; src_b = io.D_rB; end
      I_MRMOV: begin src_b = io.D_rB; dst_m = io.D_rA; end
      I_OPQ:   begin src_a = io.D_rA; src_b = io.D_rB; dst_e = io.D_rB; end
      I_CALL:  begin src_b = RSP; dst_e = RSP; end
      I_RET:   begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      I_PUSH:  begin src_a = io.D_rA; src_b = RSP; dst_e = RSP; end
      I_POP:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = io.D_rA; end
      default: ;
    endcase
  end

  // Call/jump carry the fall-through PC in valA instead of a register operand.
  assign use_valp = (io.D_icode == I_CALL) || (io.D_icode == I_JXX);
  assign val_a    = use_valp ? io.D_valP : fwd_val(src_a, rf_a);
  assign val_b    = fwd_val(src_b, rf_b);

  assign lu_stall = ((e_q.ctl.icode == I_MRMOV) || (e_q.ctl.icode == I_POP)) &&
                    (e_q.dstM != RNONE) && ((e_q.dstM == src_a) || (e_q.dstM == src_b));
  assign mispred  = (e_q.ctl.icode == I_JXX) && !io.e_cnd;

  assign e_d = '{ctl: '{icode: io.D_icode, ifun: io.D_ifun}, valC: io.D_valC,
                 valA: val_a, valB: val_b, dstE: dst_e, dstM: dst_m, srcA: src_a, srcB: src_b};

  // E register: hazards squash to a bubble even when execute asks to hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   e_q <= E_BUBBLE;
    else if (lu_stall || mispred) e_q <= E_BUBBLE;
    else if (!io.E_stall)         e_q <= e_d;
  end

  assign io.E_icode        = e_q.ctl.icode;
  assign io.E_ifun         = e_q.ctl.ifun;
  assign io.E_valC         = e_q.valC;
  assign io.E_valA         = e_q.valA;
  assign io.E_valB         = e_q.valB;
  assign io.E_dstE         = e_q.dstE;
  assign io.E_dstM         = e_q.dstM;
  assign io.E_srcA         = e_q.srcA;
  assign io.E_srcB         = e_q.srcB;
  assign io.d_srcA         = src_a;
  assign io.d_srcB         = src_b;
  assign io.load_use_stall = lu_stall;
  assign io.mispredict     = mispred;
  assign io.ret_pending    = is_ret(io.D_icode) || is_ret(e_q.ctl.icode) || is_ret(io.M_icode);

`ifdef DECODE_FWD_STATS_EN
  // A bypass hit is any source satisfied by a pipeline bus rather than the file or valP.
  function automatic logic fwd_hit(input logic [RA_W-1:0] s);
    return (s != RNONE) && ((io.e_dstE == s) || (io.M_dstM == s) || (io.M_dstE == s) ||
                            (io.W_dstM == s) || (io.W_dstE == s));
  endfunction

  logic [31:0] fwd_cnt, lu_cnt;
  logic        any_hit;

  assign any_hit = (!use_valp && fwd_hit(src_a)) || fwd_hit(src_b);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt <= '0;
      lu_cnt  <= '0;
    end else begin
      if (any_hit && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 32'd1;
      if (lu_stall && (lu_cnt != '1)) lu_cnt  <= lu_cnt + 32'd1;
    end
  end

  assign io.fwd_hits  = fwd_cnt;
  assign io.lu_stalls = lu_cnt;
`else
  assign io.fwd_hits  = '0;
  assign io.lu_stalls = '0;
`endif
endmodule

// File: tb/tb_decode_fwd_stage.sv
// Bench for decode_fwd_stage: directed scenarios then random traffic against a reference model.
// Latency: model expects E one edge after D; combinational outputs checked mid-cycle.
// Backpressure: E_stall and hazards exercised both directed and randomly.
module tb_decode_fwd_stage;
  import y86_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  decode_fwd_stage_if #(.DATA_W(64), .RA_W(4)) bus ();

  decode_fwd_stage #(.DATA_W(64), .NUM_REGS(15), .RA_W(4), .RSP_IDX(4)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog");
  end

  // Reference state
  logic [63:0] rf_m [15];
  logic [3:0]  x_icode, x_ifun, x_dstE, x_dstM, x_srcA, x_srcB;
  logic [63:0] x_valC, x_valA, x_valB;
  logic [31:0] c_fwd, c_lu;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) rf_m[i] = 64'h0;
    x_icode = I_NOP; x_ifun = 4'h0;
    x_valC = 64'h0; x_valA = 64'h0; x_valB = 64'h0;
    x_dstE = 4'hF; x_dstM = 4'hF; x_srcA = 4'hF; x_srcB = 4'hF;
    c_fwd = 32'h0; c_lu = 32'h0;
  endtask

  function automatic logic [63:0] rf_rd(input logic [3:0] a);
    return (a < 4'd15) ? rf_m[a] : 64'h0;
  endfunction

  // Instruction table: which register fields each instruction reads and writes.
  task automatic decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        output logic [3:0] sa, output logic [3:0] sb,
                        output logic [3:0] de, output logic [3:0] dm);
    sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
    if (ic == I_CMOV)       begin sa = ra; de = rb; end
    else if (ic == I_IRMOV) de = rb;
    else if (ic == I_RMMOV) begin sa = ra; sb = rb; end
    else if (ic == I_MRMOV) begin sb = rb; dm = ra; end
    else if (ic == I_OPQ)   begin sa = ra; sb = rb; de = rb; end
    else if (ic == I_CALL)  begin sb = 4'd4; de = 4'd4; end
    else if (ic == I_RET)   begin sa = 4'd4; sb = 4'd4; de = 4'd4; end
    else if (ic == I_PUSH)  begin sa = ra; sb = 4'd4; de = 4'd4; end
    else if (ic == I_POP)   begin sa = 4'd4; sb = 4'd4; de = 4'd4; dm = ra; end
  endtask

  // Scan producers from oldest to youngest so the youngest matching one is left standing.
  task automatic fwd(input logic [3:0] s, output logic [63:0] v, output logic h);
    logic [3:0]  d [5];
    logic [63:0] w [5];
    d[0] = bus.e_dstE; w[0] = bus.e_valE;
    d[1] = bus.M_dstM; w[1] = bus.m_valM;
    d[2] = bus.M_dstE; w[2] = bus.M_valE;
    d[3] = bus.W_dstM; w[3] = bus.W_valM;
    d[4] = bus.W_dstE; w[4] = bus.W_valE;
    v = 64'h0; h = 1'b0;
    if (s != 4'hF) begin
      v = rf_rd(s);
      for (int i = 4; i >= 0; i--) if (d[i] == s) begin v = w[i]; h = 1'b1; end
    end
  endtask

  task automatic set_idle();
    bus.D_icode = I_NOP; bus.D_ifun = 4'h0; bus.D_rA = 4'hF; bus.D_rB = 4'hF;
    bus.D_valC = 64'h0; bus.D_valP = 64'h0;
    bus.e_dstE = 4'hF; bus.e_valE = 64'h0; bus.e_cnd = 1'b0;
    bus.M_icode = I_NOP; bus.M_dstE = 4'hF; bus.M_dstM = 4'hF;
    bus.M_valE = 64'h0; bus.m_valM = 64'h0;
    bus.W_dstE = 4'hF; bus.W_valE = 64'h0; bus.W_dstM = 4'hF; bus.W_valM = 64'h0;
    bus.E_stall = 1'b0; bus.dbg_addr = 4'h0;
  endtask

  task automatic check_e(input string pfx);
    check({pfx, "_icode"}, 64'(bus.E_icode), 64'(x_icode));
    check({pfx, "_ifun"},  64'(bus.E_ifun),  64'(x_ifun));
    check({pfx, "_valC"},  bus.E_valC, x_valC);
    check({pfx, "_valA"},  bus.E_valA, x_valA);
    check({pfx, "_valB"},  bus.E_valB, x_valB);
    check({pfx, "_dstE"},  64'(bus.E_dstE), 64'(x_dstE));
    check({pfx, "_dstM"},  64'(bus.E_dstM), 64'(x_dstM));
    check({pfx, "_srcA"},  64'(bus.E_srcA), 64'(x_srcA));
    check({pfx, "_srcB"},  64'(bus.E_srcB), 64'(x_srcB));
  endtask

  task automatic check_stats();
`ifdef DECODE_FWD_STATS_EN
    check("fwd_hits",  64'(bus.fwd_hits),  64'(c_fwd));
    check("lu_stalls", 64'(bus.lu_stalls), 64'(c_lu));
`else
    check("fwd_hits_off",  64'(bus.fwd_hits),  64'h0);
    check("lu_stalls_off", 64'(bus.lu_stalls), 64'h0);
`endif
  endtask

  // One clock: check combinational outputs, advance the model across the edge, check E.
  task automatic tick();
    logic [3:0]  sa, sb, de, dm;
    logic [63:0] va, vb;
    logic        ha, hb, lu, mp, rp;
    #1;
    decode(bus.D_icode, bus.D_rA, bus.D_rB, sa, sb, de, dm);
    fwd(sa, va, ha);
    fwd(sb, vb, hb);
    if (bus.D_icode == I_CALL || bus.D_icode == I_JXX) begin va = bus.D_valP; ha = 1'b0; end
    lu = (x_icode == I_MRMOV || x_icode == I_POP) && x_dstM != 4'hF &&
         (x_dstM == sa || x_dstM == sb);
    mp = (x_icode == I_JXX) && !bus.e_cnd;
    rp = (bus.D_icode == I_RET) || (x_icode == I_RET) || (bus.M_icode == I_RET);
    check("d_srcA", 64'(bus.d_srcA), 64'(sa));
    check("d_srcB", 64'(bus.d_srcB), 64'(sb));
    check("load_use_stall", 64'(bus.load_use_stall), 64'(lu));
    check("mispredict", 64'(bus.mispredict), 64'(mp));
    check("ret_pending", 64'(bus.ret_pending), 64'(rp));
    check("dbg_data", bus.dbg_data, rf_rd(bus.dbg_addr));
    @(posedge clk);
    if ((ha || hb) && c_fwd != 32'hFFFF_FFFF) c_fwd = c_fwd + 32'd1;
    if (lu && c_lu != 32'hFFFF_FFFF) c_lu = c_lu + 32'd1;
    if (lu || mp) begin
      x_icode = I_NOP; x_ifun = 4'h0; x_valC = 64'h0; x_valA = 64'h0; x_valB = 64'h0;
      x_dstE = 4'hF; x_dstM = 4'hF; x_srcA = 4'hF; x_srcB = 4'hF;
    end else if (!bus.E_stall) begin
      x_icode = bus.D_icode; x_ifun = bus.D_ifun; x_valC = bus.D_valC;
      x_valA = va; x_valB = vb; x_dstE = de; x_dstM = dm; x_srcA = sa; x_srcB = sb;
    end
    if (bus.W_dstE < 4'd15) rf_m[bus.W_dstE] = bus.W_valE;
    if (bus.W_dstM < 4'd15) rf_m[bus.W_dstM] = bus.W_valM;
    #2;
    check_e("E");
    check_stats();
  endtask

  function automatic logic [3:0] pick_idx();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8)       return 4'($urandom_range(0, 7));
    else if (r == 8) return 4'hF;
    else             return 4'($urandom_range(8, 14));
  endfunction

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    set_idle();
    model_reset();
    #12;
    check_e("rst");
    check("rst_dbg", bus.dbg_data, 64'h0);
    check_stats();
    rst_n = 1'b1;

    // Register operands from the file
    bus.W_dstE = 4'd2; bus.W_valE = 64'd5; bus.W_dstM = 4'd3; bus.W_valM = 64'd7;
    tick();
    set_idle();
    bus.D_icode = I_OPQ; bus.D_rA = 4'd2; bus.D_rB = 4'd3;
    tick();
    check("opq_valA", bus.E_valA, 64'd5);
    check("opq_valB", bus.E_valB, 64'd7);
    check("opq_dstE", 64'(bus.E_dstE), 64'd3);

    // Execute bypass beats memory bypass
    bus.e_dstE = 4'd2; bus.e_valE = 64'hAA; bus.M_dstE = 4'd2; bus.M_valE = 64'hBB;
    tick();
    check("prio_valA", bus.E_valA, 64'hAA);

    // Load/use: bubble, then re-issue picks up the loaded value from M
    set_idle();
    bus.D_icode = I_MRMOV; bus.D_rA = 4'd6; bus.D_rB = 4'd1; bus.D_valC = 64'h8;
    tick();
    check("ld_in_E", 64'(bus.E_icode), 64'(I_MRMOV));
    set_idle();
    bus.D_icode = I_OPQ; bus.D_rA = 4'd6; bus.D_rB = 4'd3;
    #1;
    check("lu_flag", 64'(bus.load_use_stall), 64'h1);
    tick();
    check("lu_bubble", 64'(bus.E_icode), 64'(I_NOP));
    bus.M_icode = I_MRMOV; bus.M_dstM = 4'd6; bus.m_valM = 64'h66;
    tick();
    check("lu_reissue_valA", bus.E_valA, 64'h66);

    // Mispredict squashes even while execute holds E
    set_idle();
    bus.D_icode = I_JXX; bus.D_valP = 64'h123;
    tick();
    check("jxx_valA", bus.E_valA, 64'h123);
    set_idle();
    bus.D_icode = I_OPQ; bus.D_rA = 4'd2; bus.D_rB = 4'd3; bus.E_stall = 1'b1;
    #1;
    check("mp_flag", 64'(bus.mispredict), 64'h1);
    tick();
    check("mp_bubble", 64'(bus.E_icode), 64'(I_NOP));
    bus.E_stall = 1'b0;
    tick();
    bus.D_icode = I_IRMOV; bus.E_stall = 1'b1;
    tick();
    check("hold_icode", 64'(bus.E_icode), 64'(I_OPQ));

    // Write-port collision and RNONE write
    set_idle();
    bus.W_dstE = 4'd9; bus.W_valE = 64'd1; bus.W_dstM = 4'd9; bus.W_valM = 64'd2;
    tick();
    set_idle();
    bus.dbg_addr = 4'd9;
    bus.W_valE = 64'hDEAD;
    tick();
    check("rf_collide", bus.dbg_data, 64'd2);

    // Asynchronous reset mid-cycle
    rst_n = 1'b0;
    #1;
    model_reset();
    check_e("arst");
    check("arst_dbg", bus.dbg_data, 64'h0);
    check_stats();
    rst_n = 1'b1;

    // Three bypassed cycles, then one load/use cycle
    set_idle();
    bus.D_icode = I_OPQ; bus.D_rA = 4'd2; bus.D_rB = 4'd3; bus.e_dstE = 4'd2; bus.e_valE = 64'h11;
    repeat (3) tick();
    set_idle();
    bus.D_icode = I_MRMOV; bus.D_rA = 4'd6; bus.D_rB = 4'hF;
    tick();
    bus.D_icode = I_OPQ; bus.D_rA = 4'd6; bus.D_rB = 4'd5;
    tick();
`ifdef DECODE_FWD_STATS_EN
    check("stats_fwd3", 64'(bus.fwd_hits), 64'd3);
    check("stats_lu1", 64'(bus.lu_stalls), 64'd1);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.D_icode  = 4'($urandom_range(0, 11));
      bus.D_ifun   = 4'($urandom_range(0, 6));
      bus.D_rA     = pick_idx();
      bus.D_rB     = pick_idx();
      bus.D_valC   = rnd64();
      bus.D_valP   = rnd64();
      bus.e_dstE   = pick_idx();
      bus.e_valE   = rnd64();
      bus.e_cnd    = 1'($urandom_range(0, 1));
      bus.M_icode  = 4'($urandom_range(0, 11));
      bus.M_dstE   = pick_idx();
      bus.M_dstM   = pick_idx();
      bus.M_valE   = rnd64();
      bus.m_valM   = rnd64();
      bus.W_dstE   = pick_idx();
      bus.W_dstM   = pick_idx();
      bus.W_valE   = rnd64();
      bus.W_valM   = rnd64();
      bus.E_stall  = ($urandom_range(0, 3) == 0);
      bus.dbg_addr = 4'($urandom_range(0, 15));
      tick();
    end

    rst_n = 1'b0;
    #1;
    model_reset();
    check_e("final_rst");
    check_stats();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_fwd_stage.md
Name: decode_fwd_stage

Overview:
- Parametrised Y86-64 decode stage: register file, source/destination selection, five-source operand forwarding, load/use and mispredict hazard detection, and the D->E pipeline register.
- Sits between the fetch D-register and execute; consumes execute/memory/writeback bypass buses; owns the only copy of the architectural register file.

Parameters:
- DATA_W, 64, datapath width of register values, valC and valP.
- NUM_REGS, 15, number of architectural registers; must be < 2**RA_W.
- RA_W, 4, register-index width; RNONE = all ones (4'hF by default).
- RSP_IDX, 4, index of the stack pointer.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- D_icode, D_ifun, D_rA, D_rB  in  4/4/RA_W/RA_W  decode-register fields.
- D_valC, D_valP  in  DATA_W  constant and next PC.
- e_dstE, e_valE  in  RA_W/DATA_W  execute-stage bypass; e_dstE = RNONE for a not-taken cmov.
- e_cnd  in  1  execute condition result.
- M_icode, M_dstE, M_dstM  in  4/RA_W/RA_W  memory-stage fields.
- M_valE, m_valM  in  DATA_W  memory-stage bypass values.
- W_dstE, W_valE, W_dstM, W_valM  in  RA_W/DATA_W  writeback; these also write the register file.
- E_stall  in  1  external hold of the E register.
- E_icode, E_ifun  out  4  registered to execute.
- E_valC, E_valA, E_valB  out  DATA_W  registered operands.
- E_dstE, E_dstM, E_srcA, E_srcB  out  RA_W  registered indices.
- d_srcA, d_srcB  out  RA_W  combinational sources.
- load_use_stall  out  1  stall F/D this cycle.
- ret_pending  out  1  ret in D, E or M.
- mispredict  out  1  E holds jXX with e_cnd = 0.
- dbg_addr, dbg_data  in/out  RA_W/DATA_W  register-file peek (combinational).

Behaviour:
- Decode table; unlisted icodes give RNONE for all four fields:
  - cmovXX: srcA = rA, dstE = rB.
  - irmovq: dstE = rB.
  - rmmovq: srcA = rA, srcB = rB.
  - mrmovq: srcB = rB, dstM = rA.
  - OPq: srcA = rA, srcB = rB, dstE = rB.
  - call: srcB = RSP_IDX, dstE = RSP_IDX.
  - ret: srcA = srcB = dstE = RSP_IDX.
  - pushq: srcA = rA, srcB = dstE = RSP_IDX.
  - popq: srcA = srcB = dstE = RSP_IDX, dstM = rA.
- valA priority:
  - call or jXX: D_valP.
  - Otherwise the first match among e_dstE->e_valE, M_dstM->m_valM, M_dstE->M_valE, W_dstM->W_valM, W_dstE->W_valE.
  - Otherwise the register file.
  - valB uses the same chain without the valP case.
  - A source of RNONE never matches and reads 0.
- Register file:
  - On posedge, write W_valE to W_dstE and W_valM to W_dstM.
  - Same index on both ports: M port wins.
  - RNONE or an index >= NUM_REGS: write ignored.
  - All entries 0 on reset.
  - Reads are combinational; same-cycle writes are covered by forwarding.
- load_use_stall = E_icode in {mrmovq, popq} and E_dstM != RNONE and E_dstM in {d_srcA, d_srcB}.
- mispredict = (E_icode == jXX) && !e_cnd.
- ret_pending = ret present in D_icode, E_icode or M_icode.
- E register update priority:
  1. rst_n low: bubble.
  2. load_use_stall or mispredict: bubble (overrides E_stall).
  3. E_stall: hold.
  4. Otherwise load the decoded values.
- Bubble contents: icode = NOP (4'h1), ifun 0, values 0, all indices RNONE.
- Latency: one cycle from D inputs to E outputs.
- Reset asserted mid-operation clears the E register and register file immediately, regardless of clock.

Optional Feature:
- Macro DECODE_FWD_STATS_EN.
- Defined:
  - Output fwd_hits (32 bits) increments by 1 per cycle in which a non-regfile, non-valP source feeds valA or valB, saturating at all ones.
  - Output lu_stalls (32 bits) counts load_use_stall cycles, also saturating.
  - Both counters clear on reset.
- Undefined: both ports present and tied to 0, no counter flops.

Decomposition:
- Package y86_pkg holds:
  - icode constants (HALT, NOP, CMOV, IRMOV, RMMOV, MRMOV, OPQ, JXX, CALL, RET, PUSH, POP);
  - RNONE and RSP_IDX defaults;
  - a bubble struct/typedef for the E register.
- One sub-module, y86_regfile: NUM_REGS x DATA_W, two write ports, two read ports plus the debug read port, async reset.
- Forwarding mux and hazard logic stay in decode_fwd_stage.

Test Plan:
- Reset, then OPq rA = 2, rB = 3 with all bypass indices RNONE and regs 2/3 written 5/7 → next cycle E_valA = 5, E_valB = 7, E_dstE = 3.
- OPq srcA = 2 with e_dstE = 2 (e_valE = 0xAA) and M_dstE = 2 (M_valE = 0xBB) → E_valA = 0xAA (priority check).
- E holds mrmovq with dstM = 6; D is OPq rA = 6 → load_use_stall = 1 and E becomes a NOP bubble the next cycle; a stalled re-issue then forwards m_valM.
- E holds jXX with e_cnd = 0, and E_stall = 1 → mispredict = 1 and E is bubbled, not held.
- W_dstE = W_dstM = 9 with W_valE = 1, W_valM = 2 → dbg_addr = 9 reads 2; W_dstE = RNONE leaves the file unchanged.
- With DECODE_FWD_STATS_EN defined, 3 forwarded cycles and 1 load-use cycle → fwd_hits = 3, lu_stalls = 1; async rst_n pulse → both 0 and E = bubble.
